// File: rtl/parameters_pkg.sv
// rtl/parameters_pkg.sv - shared widths, defaults and arbiter state type
package parameters_pkg;
    localparam int DATA_WIDTH   = 8;
    localparam int NUM_REQ      = 4;
    localparam int REQ_ID_WIDTH = $clog2(NUM_REQ);

    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;
endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - requester/FIFO-side bundle of the write arbiter
// REQ_LAST exists only when ARB_BURST_EN is defined.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = parameters_pkg::NUM_REQ,
    parameter int DATA_WIDTH = parameters_pkg::DATA_WIDTH,
    parameter int CNT_WIDTH  = 16
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            REQ_VALID;
    logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA;
    logic [NUM_REQ-1:0]            REQ_READY;
    logic                          FULL;
    logic                          W_INC;
    logic [DATA_WIDTH-1:0]         WR_DATA;
    logic [ID_W-1:0]               GNT_ID;
    logic [CNT_WIDTH-1:0]          WR_COUNT;
`ifdef ARB_BURST_EN
    logic [NUM_REQ-1:0]            REQ_LAST;

    modport master (
        output REQ_VALID, REQ_DATA, REQ_LAST, FULL,
        input  REQ_READY, W_INC, WR_DATA, GNT_ID, WR_COUNT
    );
    modport slave (
        input  REQ_VALID, REQ_DATA, REQ_LAST, FULL,
        output REQ_READY, W_INC, WR_DATA, GNT_ID, WR_COUNT
    );
`else
    modport master (
        output REQ_VALID, REQ_DATA, FULL,
        input  REQ_READY, W_INC, WR_DATA, GNT_ID, WR_COUNT
    );
    modport slave (
        input  REQ_VALID, REQ_DATA, FULL,
        output REQ_READY, W_INC, WR_DATA, GNT_ID, WR_COUNT
    );
`endif
endinterface

// File: rtl/fifo_wr_arbiter_rr_arbiter_core.sv
// rtl/fifo_wr_arbiter_rr_arbiter_core.sv - combinational rotating-priority picker
module rr_arbiter_core #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    last_gnt_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               any_o
);
    int cand;

    // Search starts just after the previous winner and wraps modulo NUM_REQ.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last_gnt_i) + k) % NUM_REQ;
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                idx_o       = ID_W'(cand);
                gnt_o[cand] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin arbiter sharing one FIFO write port
// Optional burst locking enabled by defining ARB_BURST_EN.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = parameters_pkg::NUM_REQ,
    parameter int DATA_WIDTH = parameters_pkg::DATA_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    fifo_wr_arbiter_if.slave  bus
);
    import parameters_pkg::*;

    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0]      last_gnt_q, last_gnt_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [NUM_REQ-1:0]   eligible;
    logic [NUM_REQ-1:0]   gnt;
    logic [ID_W-1:0]      win;
    logic                 any;
    logic                 fire;

`ifdef ARB_BURST_EN
    arb_state_t      state_q, state_d;
    logic [ID_W-1:0] owner_q, owner_d;

    // A locked burst masks every requester except its owner.
    always_comb begin
        eligible = bus.REQ_VALID;
        if (state_q == ARB_LOCKED) begin
            eligible = bus.REQ_VALID & (NUM_REQ'(1) << owner_q);
        end
    end
`else
    assign eligible = bus.REQ_VALID;
`endif

    rr_arbiter_core #(.NUM_REQ(NUM_REQ)) u_core (
        .req_i      (eligible),
        .last_gnt_i (last_gnt_q),
        .gnt_o      (gnt),
        .idx_o      (win),
        .any_o      (any)
    );

    assign fire          = any & ~bus.FULL & ~RST;
    assign bus.REQ_READY = fire ? gnt : '0;
    assign bus.W_INC     = fire;
    assign bus.WR_DATA   = fire ? bus.REQ_DATA[win*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign bus.GNT_ID    = fire ? win : '0;
    assign bus.WR_COUNT  = count_q;

    always_comb begin
        last_gnt_d = last_gnt_q;
        count_d    = count_q;
`ifdef ARB_BURST_EN
        state_d    = state_q;
        owner_d    = owner_q;
`endif
        if (fire) begin
            last_gnt_d = win;
            count_d    = count_q + 1'b1;
`ifdef ARB_BURST_EN
            if (state_q == ARB_IDLE && !bus.REQ_LAST[win]) begin
                state_d = ARB_LOCKED;
                owner_d = win;
            end else if (state_q == ARB_LOCKED && bus.REQ_LAST[win]) begin
                state_d = ARB_IDLE;
            end
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            last_gnt_q <= ID_W'(NUM_REQ - 1);
            count_q    <= '0;
`ifdef ARB_BURST_EN
            state_q    <= ARB_IDLE;
            owner_q    <= '0;
`endif
        end else begin
            last_gnt_q <= last_gnt_d;
            count_q    <= count_d;
`ifdef ARB_BURST_EN
            state_q    <= state_d;
            owner_q    <= owner_d;
`endif
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for fifo_wr_arbiter (ARB_BURST_EN aware)
module tb_fifo_wr_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    typedef struct {
        logic [N-1:0]  rdy;
        logic          w;
        logic [DW-1:0] data;
        logic [1:0]    id;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    // Reference state: previous winner, accepted-write tally, burst owner (-1 = none)
    int m_last  = N - 1;
    int m_cnt   = 0;
    int m_owner = -1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    task automatic step(input logic [N-1:0] v, input logic f, input logic r, input logic [N-1:0] l);
        logic [N*DW-1:0] d;
        exp_t e;
        int win;
        @(posedge clk);
        #1;
        d = {$urandom, $urandom};
        rst           = r;
        bus.REQ_VALID = v;
        bus.REQ_DATA  = d;
        bus.FULL      = f;
`ifdef ARB_BURST_EN
        bus.REQ_LAST  = l;
`endif
        e.rdy  = '0;
        e.w    = 1'b0;
        e.data = '0;
        e.id   = '0;
        e.cnt  = CW'(m_cnt);
        if (r) begin
            m_last  = N - 1;
            m_cnt   = 0;
            m_owner = -1;
        end else begin
            win = -1;
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (m_last + k) % N;
                if (win < 0 && v[i] && (m_owner < 0 || m_owner == i)) win = i;
            end
            if (win >= 0 && !f) begin
                e.w    = 1'b1;
                e.id   = 2'(win);
                e.rdy  = N'(1) << win;
                e.data = d[win*DW +: DW];
                m_last = win;
                m_cnt  = (m_cnt + 1) % (1 << CW);
`ifdef ARB_BURST_EN
                if (m_owner < 0) begin
                    if (!l[win]) m_owner = win;
                end else if (l[win]) begin
                    m_owner = -1;
                end
`endif
            end
        end
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("ready",    32'(bus.REQ_READY), 32'(e.rdy));
            chk("w_inc",    32'(bus.W_INC),     32'(e.w));
            chk("wr_data",  32'(bus.WR_DATA),   32'(e.data));
            chk("gnt_id",   32'(bus.GNT_ID),    32'(e.id));
            chk("wr_count", 32'(bus.WR_COUNT),  32'(e.cnt));
        end
    end

    initial begin
        bus.REQ_VALID = '1;
        bus.REQ_DATA  = '0;
        bus.FULL      = 1'b0;
`ifdef ARB_BURST_EN
        bus.REQ_LAST  = '1;
`endif
        repeat (3) step(4'b1111, 1'b0, 1'b1, 4'b1111);
        repeat (8) step(4'b1111, 1'b0, 1'b0, 4'b1111);
        repeat (3) step(4'b1010, 1'b0, 1'b0, 4'b1111);
        step(4'b0100, 1'b0, 1'b0, 4'b1111);
        repeat (3) step(4'b1111, 1'b1, 1'b0, 4'b1111);
        step(4'b1111, 1'b0, 1'b0, 4'b1111);
        // 17 writes from here wrap the 4-bit counter
        repeat (17) step(4'b0001, 1'b0, 1'b0, 4'b1111);
`ifdef ARB_BURST_EN
        step(4'b0001, 1'b0, 1'b0, 4'b1111);
        step(4'b0111, 1'b0, 1'b0, 4'b0000);
        step(4'b0101, 1'b0, 1'b0, 4'b0000);
        step(4'b0111, 1'b1, 1'b0, 4'b0000);
        step(4'b0111, 1'b0, 1'b0, 4'b0010);
        step(4'b0111, 1'b0, 1'b0, 4'b0100);
        step(4'b0111, 1'b0, 1'b0, 4'b0000);
        step(4'b0111, 1'b0, 1'b1, 4'b0000);
        step(4'b0111, 1'b0, 1'b0, 4'b1111);
`endif
        repeat (3000) begin
            step(N'($urandom), ($urandom % 5) == 0, ($urandom % 200) == 0, N'($urandom));
        end
        step(4'b0000, 1'b0, 1'b0, 4'b0000);
        @(negedge clk);
        #1;
        chk("drain", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
